// File: rtl/alu16_if.sv
// Operand/result bundle between the X/Y operand latches, the ALU and the Z latch.
// master: microcode/operand side, drives operands and control.
// slave:  the ALU core.
interface alu16_if;
    logic        mode;
    logic [3:0]  alu_op;
    logic        c_in;
    logic [15:0] x;
    logic [15:0] y;
    logic        z_load;
    logic [15:0] alu_z;
    logic [15:0] z;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        overflow;

    modport master (
        output mode, alu_op, c_in, x, y, z_load,
        input  alu_z, z, carry, zero, negative, overflow
    );

    modport slave (
        input  mode, alu_op, c_in, x, y, z_load,
        output alu_z, z, carry, zero, negative, overflow
    );
endinterface

// File: rtl/alu16_core.sv
// 16-bit 74181-style ALU with combinational result alu_z and a loadable Z register.
// Build option ALU16_FLAGS_EN: when defined, carry/zero/negative/overflow are
// registered alongside Z; when undefined, no flag registers exist and the four
// flag outputs are tied to 0.
// Unselected op codes (X/Z on alu_op) drive X so illegal microinstructions stay visible.
module alu16_core (
    input  logic   clk,
    input  logic   reset,
    alu16_if.slave bus
);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [15:0] q;
    logic [15:0] logic_z;
    logic [15:0] alu_z;
    logic [15:0] z_d;
    logic [15:0] z_q;

    assign a = bus.x;
    assign b = bus.y;

    // Logic-mode function table.
    always_comb begin
        logic_z = 'x;
        case (bus.alu_op)
            4'h0: logic_z = ~a;
            4'h1: logic_z = ~(a | b);
            4'h2: logic_z = ~a & b;
            4'h3: logic_z = 16'h0000;
            4'h4: logic_z = ~(a & b);
            4'h5: logic_z = ~b;
            4'h6: logic_z = a ^ b;
            4'h7: logic_z = a & ~b;
            4'h8: logic_z = ~a | b;
            4'h9: logic_z = ~(a ^ b);
            4'hA: logic_z = b;
            4'hB: logic_z = a & b;
            4'hC: logic_z = 16'hFFFF;
            4'hD: logic_z = a | ~b;
            4'hE: logic_z = a | b;
            4'hF: logic_z = a;
            default: logic_z = 'x;
        endcase
    end

    // Arithmetic-mode adder operand selection (result = P + Q + c_in).
    always_comb begin
        p = 'x;
        q = 'x;
        case (bus.alu_op)
            4'h0: begin p = a;      q = 16'h0000; end
            4'h1: begin p = a | b;  q = 16'h0000; end
            4'h2: begin p = a | ~b; q = 16'h0000; end
            4'h3: begin p = 16'h0000; q = 16'hFFFF; end
            4'h4: begin p = a;      q = a & ~b;   end
            4'h5: begin p = a | b;  q = a & ~b;   end
            4'h6: begin p = a;      q = ~b;       end
            4'h7: begin p = a & ~b; q = 16'hFFFF; end
            4'h8: begin p = a;      q = a & b;    end
            4'h9: begin p = a;      q = b;        end
            4'hA: begin p = a | ~b; q = a & b;    end
            4'hB: begin p = a & b;  q = 16'hFFFF; end
            4'hC: begin p = a;      q = a;        end
            4'hD: begin p = a | b;  q = a;        end
            4'hE: begin p = a | ~b; q = a;        end
            4'hF: begin p = a;      q = 16'hFFFF; end
            default: begin p = 'x; q = 'x; end
        endcase
    end

`ifdef ALU16_FLAGS_EN
    // Full 17-bit sum so the carry-out is available for the flag register.
    logic [16:0] sum;
    assign sum = {1'b0, p} + {1'b0, q} + {16'h0000, bus.c_in};
`else
    // Without flags the carry-out has no consumer, so the adder stays 16 bits.
    logic [15:0] sum;
    assign sum = p + q + {15'h0000, bus.c_in};
`endif

    assign alu_z     = bus.mode ? logic_z : sum[15:0];
    assign bus.alu_z = alu_z;

    // Next Z: capture on z_load, otherwise hold.
    always_comb begin
        z_d = bus.z_load ? alu_z : z_q;
    end

    // Z register; reset overrides any pending load.
    always_ff @(posedge clk) begin
        if (reset) z_q <= 16'h0000;
        else       z_q <= z_d;
    end

    assign bus.z = z_q;

`ifdef ALU16_FLAGS_EN
    // Flags packed as {carry, zero, negative, overflow}.
    logic [3:0] flags_c;
    logic [3:0] flags_d;
    logic [3:0] flags_q;

    // Flags computed alongside alu_z; carry/overflow only exist in arithmetic mode.
    always_comb begin
        flags_c[3] = bus.mode ? 1'b0 : sum[16];
        flags_c[2] = (alu_z == 16'h0000);
        flags_c[1] = alu_z[15];
        flags_c[0] = bus.mode ? 1'b0 : ((p[15] == q[15]) && (sum[15] != p[15]));
        flags_d    = bus.z_load ? flags_c : flags_q;
    end

    // Flag register, loaded and reset together with Z.
    always_ff @(posedge clk) begin
        if (reset) flags_q <= 4'h0;
        else       flags_q <= flags_d;
    end

    assign bus.carry    = flags_q[3];
    assign bus.zero     = flags_q[2];
    assign bus.negative = flags_q[1];
    assign bus.overflow = flags_q[0];
`else
    assign bus.carry    = 1'b0;
    assign bus.zero     = 1'b0;
    assign bus.negative = 1'b0;
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu16_core.sv
// Bench for alu16_core: reference model of the ALU tables, a Z/flag register
// model, one compare process on every falling edge, and literal checks.
module tb_alu16_core;
    logic clk = 1'b0;
    logic reset;

    alu16_if bus();

    alu16_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

`ifdef ALU16_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: outputs straight from the function tables.
    function automatic void model(input logic m, input logic [3:0] op, input logic ci,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] fl);
        logic [15:0] p, q;
        logic [31:0] s;
        logic c, ov;
        c = 1'b0; ov = 1'b0; p = '0; q = '0; r = '0;
        if (m) begin
            case (op)
                4'h0: r = ~a;        4'h1: r = ~(a | b);
                4'h2: r = ~a & b;    4'h3: r = 16'h0000;
                4'h4: r = ~(a & b);  4'h5: r = ~b;
                4'h6: r = a ^ b;     4'h7: r = a & ~b;
                4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);
                4'hA: r = b;         4'hB: r = a & b;
                4'hC: r = 16'hFFFF;  4'hD: r = a | ~b;
                4'hE: r = a | b;     default: r = a;
            endcase
        end else begin
            case (op)
                4'h0: begin p = a;      q = 16'h0000; end
                4'h1: begin p = a | b;  q = 16'h0000; end
                4'h2: begin p = a | ~b; q = 16'h0000; end
                4'h3: begin p = 16'h0;  q = 16'hFFFF; end
                4'h4: begin p = a;      q = a & ~b;   end
                4'h5: begin p = a | b;  q = a & ~b;   end
                4'h6: begin p = a;      q = ~b;       end
                4'h7: begin p = a & ~b; q = 16'hFFFF; end
                4'h8: begin p = a;      q = a & b;    end
                4'h9: begin p = a;      q = b;        end
                4'hA: begin p = a | ~b; q = a & b;    end
                4'hB: begin p = a & b;  q = 16'hFFFF; end
                4'hC: begin p = a;      q = a;        end
                4'hD: begin p = a | b;  q = a;        end
                4'hE: begin p = a | ~b; q = a;        end
                default: begin p = a;   q = 16'hFFFF; end
            endcase
            s  = 32'(p) + 32'(q) + 32'(ci);
            r  = s[15:0];
            c  = s[16];
            ov = (p[15] == q[15]) && (s[15] != p[15]);
        end
        fl = {c, (r == 16'h0000), r[15], ov};
        if (!FL) fl = 4'h0;
    endfunction

    // Expected register contents.
    logic [15:0] ez  = '0;
    logic [3:0]  efl = '0;

    always @(posedge clk) begin
        logic [15:0] r;
        logic [3:0]  f;
        if (reset) begin
            ez  = 16'h0000;
            efl = 4'h0;
        end else if (bus.z_load) begin
            model(bus.mode, bus.alu_op, bus.c_in, bus.x, bus.y, r, f);
            ez  = r;
            efl = f;
        end
    end

    always @(negedge clk) begin
        logic [15:0] r;
        logic [3:0]  f;
        if (cmp_en) begin
            model(bus.mode, bus.alu_op, bus.c_in, bus.x, bus.y, r, f);
            chk("alu_z", bus.alu_z, r);
            chk("z", bus.z, ez);
            chk("flags", {12'h0, bus.carry, bus.zero, bus.negative, bus.overflow}, {12'h0, efl});
        end
    end

    task automatic drive(input logic r, input logic m, input logic [3:0] op, input logic ci,
                         input logic [15:0] a, input logic [15:0] b, input logic ld);
        reset      = r;
        bus.mode   = m;
        bus.alu_op = op;
        bus.c_in   = ci;
        bus.x      = a;
        bus.y      = b;
        bus.z_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal flag check: {carry, zero, negative, overflow}, gated by the build option.
    task automatic chk_fl(input string nm, input logic [3:0] exp);
        chk(nm, {12'h0, bus.carry, bus.zero, bus.negative, bus.overflow}, {12'h0, exp & {4{FL}}});
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk("reset_z", bus.z, 16'h0000);
        chk_fl("reset_flags", 4'h0);
        cmp_en = 1'b1;

        drive(1'b1, 1'b0, 4'h9, 1'b0, 16'h1234, 16'h0FED, 1'b1);
        tick();
        chk("reset_beats_load", bus.z, 16'h0000);

        drive(1'b0, 1'b0, 4'h9, 1'b0, 16'h1234, 16'h0FED, 1'b1);
        #1 chk("add_alu_z", bus.alu_z, 16'h2221);
        tick();
        chk("add_z", bus.z, 16'h2221);
        chk_fl("add_flags", 4'b0000);

        drive(1'b0, 1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 1'b1);
        tick();
        chk("wrap_z", bus.z, 16'h0000);
        chk_fl("wrap_flags", 4'b1100);

        drive(1'b0, 1'b0, 4'h6, 1'b1, 16'h7FFF, 16'hFFFF, 1'b1);
        tick();
        chk("sub_ovf_z", bus.z, 16'h8000);
        chk_fl("sub_ovf_flags", 4'b0011);

        drive(1'b0, 1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 1'b1);
        tick();
        chk("xor_z", bus.z, 16'h0FF0);
        chk_fl("xor_flags", 4'b0000);

        drive(1'b0, 1'b1, 4'h6, 1'b1, 16'h1111, 16'h2222, 1'b0);
        #1 chk("hold_alu_z", bus.alu_z, 16'h3333);
        tick();
        chk("hold_z", bus.z, 16'h0FF0);

        drive(1'b0, 1'b1, 4'h0, 1'b0, 16'hA5C3, 16'h3C5A, 1'b0);
        #1 chk("sweep_not_a", bus.alu_z, 16'h5A3C);
        drive(1'b0, 1'b0, 4'h9, 1'b0, 16'hA5C3, 16'h3C5A, 1'b0);
        #1 chk("sweep_add", bus.alu_z, 16'hE21D);
        drive(1'b0, 1'b0, 4'h9, 1'b1, 16'hA5C3, 16'h3C5A, 1'b0);
        #1 chk("sweep_add_c", bus.alu_z, 16'hE21E);

        for (int i = 0; i < 64; i++) begin
            drive(1'b0, i[4], i[3:0], i[5], 16'hA5C3, 16'h3C5A, 1'b1);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end

        drive(1'b0, 1'b0, 4'h0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        chk("inc_wrap_z", bus.z, 16'h0000);
        chk_fl("inc_wrap_flags", 4'b1100);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
